mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator for the data memory interface, sitting in the MEM stage between the EX/MEM pipeline register and a variable-latency data memory responder.
- Converts the MEM-stage MemRead/MemWrite control pair into a valid/ready request plus response handshake.
- Holds the pipeline with a stall output until the access completes.
- Reports protocol and usage errors in a sticky error code.

Parameters:
- TIMEOUT, 64: max cycles from request issue to response before abort; legal range 2..65535.
- CNT_W, 16: width of the timeout counter.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  reset.
- MemRead  in  1  MEM-stage load request.
- MemWrite  in  1  MEM-stage store request.
- Address  in  32  byte address from ALU result.
- WriteData  in  32  store data.
- stall  out  1  hold IF..MEM pipeline registers.
- done  out  1  one-cycle completion pulse.
- ReadData  out  32  load result to MEM/WB.
- err_code  out  2  sticky error: 0 none, 1 read+write conflict, 2 misaligned, 3 timeout.
- req_valid  out  1  request to memory.
- req_ready  in  1  memory accepts request.
- req_write  out  1  1 = store, 0 = load.
- req_address  out  32  latched word address (byte address, [1:0]=0).
- req_wdata  out  32  latched store data.
- resp_valid  in  1  memory response/ack.
- resp_rdata  in  32  load data.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset is sampled at posedge clock.
- Reset values: state=IDLE, req_valid=0, req_write=0, req_address=0, req_wdata=0, ReadData=0, done=0, err_code=0, timeout counter=0.
- start = (MemRead ^ MemWrite) && (Address[1:0]==0).
- States: IDLE, REQ, WAIT, DONE.
- stall (combinational) = (IDLE && start) || REQ || WAIT. It is 0 in DONE so the pipeline advances on the edge that leaves DONE.
- IDLE:
  - If start: latch Address, WriteData and req_write=MemWrite. Go to REQ; req_valid=1 from next cycle.
  - If MemRead && MemWrite: no access, no stall; err_code<=1 if currently 0.
  - If exactly one of MemRead/MemWrite is set and Address[1:0]!=0: no access, no stall; err_code<=2 if currently 0.
- REQ:
  - req_valid=1; req_write/req_address/req_wdata held stable.
  - req_ready=1 at a posedge → WAIT, req_valid drops next cycle.
  - req_ready=1 and resp_valid=1 on the same edge → straight to DONE; treated as completion.
  - resp_valid alone in REQ is ignored.
- WAIT:
  - resp_valid=1 → DONE.
  - For a load, ReadData<=resp_rdata on that edge. Stores leave ReadData unchanged; resp_valid is their ack.
- Timeout:
  - Counter clears on IDLE→REQ and increments every cycle in REQ or WAIT.
  - When counter==TIMEOUT-1 without completion → DONE, req_valid<=0, err_code<=3 if currently 0.
  - A timed-out load returns ReadData=0.
  - Completion on the same edge as expiry wins; no error.
- DONE:
  - done=1 for exactly one cycle, then IDLE unconditionally.
  - Inputs sampled in DONE are ignored; the next request is recognised in the following IDLE cycle.
- Minimum latency: start seen in cycle 0 → REQ in cycle 1 → WAIT in cycle 2 (ready in cycle 1) → DONE in cycle 3 (resp in cycle 2). Stall is high in cycles 0-2.
- err_code holds the first error only and clears only on reset; it never blocks later accesses.
- Late responses: a resp_valid arriving in IDLE or DONE (e.g. after timeout or reset) is ignored.
- Reset mid-transaction: next cycle is IDLE with req_valid=0; any partially captured data is discarded.
- Internal address/data are full 32-bit; no arithmetic other than the counter. The counter saturates at TIMEOUT-1, never wraps.

Test Plan:
- Load, zero-wait memory: MemRead=1, Address=0x40, ready high, resp_rdata=0x12345678 one cycle after accept → req_valid 1 cycle, stall 3 cycles, done pulse, ReadData=0x12345678, err_code=0.
- Store with backpressure: MemWrite=1, Address=0x84, WriteData=0xCAFEF00D, req_ready low 4 cycles → req_valid held 5 cycles with address/data stable, then WAIT; ack → done, ReadData unchanged.
- Same-edge ready+resp in REQ: load with req_ready and resp_valid both high on first REQ edge → DONE directly, stall 2 cycles, data captured.
- Errors: MemRead=MemWrite=1 → no req_valid, stall=0, err_code=1. Then misaligned load 0x42 → err_code stays 1.
- Timeout with TIMEOUT=8: load with no response → DONE after 8 REQ/WAIT cycles, ReadData=0, err_code=3. A resp_valid two cycles later is ignored.
- Reset in WAIT: assert reset one cycle → req_valid=0, stall=0, err_code=0. Next load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data memory initiator with stall, timeout and sticky error code
module mem_access_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        stall,
    output logic        done,
    output logic [31:0] ReadData,
    output logic [1:0]  err_code,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [31:0] req_address,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             start, conflict, misaligned, active, complete, expire;

    always_comb begin
        conflict   = MemRead & MemWrite;
        start      = (MemRead ^ MemWrite) && (Address[1:0] == 2'b00);
        misaligned = (MemRead ^ MemWrite) && (Address[1:0] != 2'b00);
        active     = (state == S_REQ) || (state == S_WAIT);
        // A response together with acceptance in REQ counts as completion.
        complete   = ((state == S_REQ) && req_ready && resp_valid) ||
                     ((state == S_WAIT) && resp_valid);
        expire     = active && (cnt == CNT_LAST) && !complete;
    end

    assign req_valid = (state == S_REQ);
    assign done      = (state == S_DONE);
    assign stall     = ((state == S_IDLE) && start) || active;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_REQ;
            S_REQ: begin
                if (complete || expire) next_state = S_DONE;
                else if (req_ready)     next_state = S_WAIT;
            end
            S_WAIT: if (complete || expire) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_write   <= 1'b0;
            req_address <= '0;
            req_wdata   <= '0;
            ReadData    <= '0;
            err_code    <= 2'd0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        req_write   <= MemWrite;
                        req_address <= {Address[31:2], 2'b00};
                        req_wdata   <= WriteData;
                    end else if (conflict && err_code == 2'd0) begin
                        err_code <= 2'd1;
                    end else if (misaligned && err_code == 2'd0) begin
                        err_code <= 2'd2;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (cnt != CNT_LAST)
                        cnt <= cnt + CNT_W'(1);
                    if (complete) begin
                        if (!req_write)
                            ReadData <= resp_rdata;
                    end else if (expire) begin
                        if (!req_write)
                            ReadData <= '0;
                        if (err_code == 2'd0)
                            err_code <= 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
